// File: rtl/tile_grid_compositor.sv
// tile_grid_compositor
//   Draws a COLS x ROWS grid of equal rectangular tiles on the VGA raster.
//   Each tile's brightness comes from a per-tile level. Levels are written
//   through a valid/ready port into a back bank. The back bank becomes the
//   displayed (front) bank only at frame start, so a frame never shows a
//   half-updated grid.
//
//   Optional build macro: TILE_BORDER_EN
//     When defined, each tile's outermost pixel row/column is drawn white.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   iVGA_X[9:0]           current pixel x
//   iVGA_Y[8:0]           current pixel y
//   iWrValid / oWrReady   level write handshake (ready low only in a swap cycle)
//   iWrIdx[IDX_W-1:0]     tile index, col*ROWS + row (column-major)
//   iWrLevel[LEVEL_W-1:0] new level for that tile
//   oWrErr                sticky: an out-of-range index was written
//   oSwapped              one-cycle pulse after the banks swap
//   oR / oG / oB [7:0]    registered pixel colour, 3 cycles after iVGA_X/Y
module tile_grid_compositor #(
  parameter int COLS     = 6,
  parameter int ROWS     = 6,
  parameter int ORIGIN_X = 10,
  parameter int ORIGIN_Y = 10,
  parameter int PITCH_X  = 105,
  parameter int PITCH_Y  = 79,
  parameter int TILE_W   = 95,
  parameter int TILE_H   = 69,
  parameter int LEVEL_W  = 4,
  parameter logic [7:0] BG_R = 8'h00,
  parameter logic [7:0] BG_G = 8'h00,
  parameter logic [7:0] BG_B = 8'h00,
  localparam int NT    = COLS * ROWS,
  localparam int IDX_W = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         iVGA_X,
  input  logic [8:0]         iVGA_Y,
  input  logic               iWrValid,
  output logic               oWrReady,
  input  logic [IDX_W-1:0]   iWrIdx,
  input  logic [LEVEL_W-1:0] iWrLevel,
  output logic               oWrErr,
  output logic               oSwapped,
  output logic [7:0]         oR,
  output logic [7:0]         oG,
  output logic [7:0]         oB
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // ---------------- level banks and swap control ----------------
  logic [LEVEL_W-1:0] bank0_q [NT];
  logic [LEVEL_W-1:0] bank1_q [NT];
  logic sel_q, sel_d;        // 0: bank0 is front, 1: bank1 is front
  logic dirty_q, dirty_d;
  logic err_q, err_d;
  logic swapped_q;
  logic prev_zero_q;         // previous sampled position was (0,0)

  logic at_zero, fs, swap, wr_fire, idx_ok, wr_ok;

  assign at_zero  = (iVGA_X == 10'd0) && (iVGA_Y == 9'd0);
  assign fs       = at_zero && !prev_zero_q;
  assign swap     = fs && dirty_q;
  assign oWrReady = !swap;
  assign wr_fire  = iWrValid && oWrReady;
  assign idx_ok   = (32'(iWrIdx) < 32'(NT));
  assign wr_ok    = wr_fire && idx_ok;

  always_comb begin
    sel_d   = sel_q;
    dirty_d = dirty_q;
    err_d   = err_q;
    if (swap) begin
      sel_d   = !sel_q;
      dirty_d = 1'b0;
    end else if (wr_ok) begin
      dirty_d = 1'b1;
    end
    if (wr_fire && !idx_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= 1'b0;
      dirty_q     <= 1'b0;
      err_q       <= 1'b0;
      swapped_q   <= 1'b0;
      prev_zero_q <= 1'b0;
      for (int i = 0; i < NT; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else begin
      sel_q       <= sel_d;
      dirty_q     <= dirty_d;
      err_q       <= err_d;
      swapped_q   <= swap;
      prev_zero_q <= at_zero;
      // On a swap the old back becomes front; the old front (new back) is
      // refreshed from it so later writes start from what is displayed.
      if (swap) begin
        if (sel_q) bank1_q <= bank0_q;
        else       bank0_q <= bank1_q;
      end else if (wr_ok) begin
        if (sel_q) bank0_q[iWrIdx] <= iWrLevel;
        else       bank1_q[iWrIdx] <= iWrLevel;
      end
    end
  end

  assign oWrErr   = err_q;
  assign oSwapped = swapped_q;

  // ---------------- S1: tile lookup ----------------
  logic [31:0] x_ext, y_ext, left_x, top_y;
  logic [CW-1:0] col_s1_d, col_s1_q;
  logic [RW-1:0] row_s1_d, row_s1_q;
  logic in_s1_d, in_s1_q, vld_s1_q;

  assign x_ext = 32'(iVGA_X);
  assign y_ext = 32'(iVGA_Y);

  // Tile origins increase monotonically, so the last origin passed wins.
  always_comb begin
    col_s1_d = '0;
    left_x   = 32'(ORIGIN_X);
    for (int c = 1; c < COLS; c++) begin
      if (x_ext >= 32'(ORIGIN_X + c * PITCH_X)) begin
        col_s1_d = CW'(c);
        left_x   = 32'(ORIGIN_X + c * PITCH_X);
      end
    end
    row_s1_d = '0;
    top_y    = 32'(ORIGIN_Y);
    for (int r = 1; r < ROWS; r++) begin
      if (y_ext >= 32'(ORIGIN_Y + r * PITCH_Y)) begin
        row_s1_d = RW'(r);
        top_y    = 32'(ORIGIN_Y + r * PITCH_Y);
      end
    end
    in_s1_d = (x_ext >= left_x) && (x_ext < left_x + 32'(TILE_W)) &&
              (y_ext >= top_y)  && (y_ext < top_y  + 32'(TILE_H));
  end

`ifdef TILE_BORDER_EN
  logic bdr_s1_d, bdr_s1_q, bdr_s2_q;
  assign bdr_s1_d = in_s1_d &&
                    ((x_ext == left_x) || (x_ext == left_x + 32'(TILE_W - 1)) ||
                     (y_ext == top_y)  || (y_ext == top_y  + 32'(TILE_H - 1)));
  always_ff @(posedge clk) begin
    if (reset) begin
      bdr_s1_q <= 1'b0;
      bdr_s2_q <= 1'b0;
    end else begin
      bdr_s1_q <= bdr_s1_d;
      bdr_s2_q <= bdr_s1_q;
    end
  end
`endif

  // ---------------- S2: front-bank level read ----------------
  logic [IDX_W-1:0]   rd_idx;
  logic [LEVEL_W-1:0] front_lvl, lvl_s2_q;
  logic in_s2_q, col0_s2_q, vld_s2_q;

  assign rd_idx    = IDX_W'(int'(col_s1_q) * ROWS + int'(row_s1_q));
  assign front_lvl = sel_q ? bank1_q[rd_idx] : bank0_q[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      col_s1_q  <= '0;
      row_s1_q  <= '0;
      in_s1_q   <= 1'b0;
      vld_s1_q  <= 1'b0;
      lvl_s2_q  <= '0;
      in_s2_q   <= 1'b0;
      col0_s2_q <= 1'b0;
      vld_s2_q  <= 1'b0;
    end else begin
      col_s1_q  <= col_s1_d;
      row_s1_q  <= row_s1_d;
      in_s1_q   <= in_s1_d;
      vld_s1_q  <= 1'b1;
      lvl_s2_q  <= front_lvl;
      in_s2_q   <= in_s1_q;
      col0_s2_q <= col_s1_q[0];
      vld_s2_q  <= vld_s1_q;
    end
  end

  // ---------------- S3: colour ----------------
  logic [7:0] lvl8;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rep
      // Repeat the level pattern from the MSB down to fill 8 bits.
      assign lvl8[gi] = lvl_s2_q[LEVEL_W - 1 - ((7 - gi) % LEVEL_W)];
    end
  endgenerate

  logic [7:0] r_d, g_d, b_d, r_q, g_q, b_q;
  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (vld_s2_q) begin
      if (in_s2_q) begin
        r_d = lvl8;
        g_d = lvl8 >> 1;
        b_d = col0_s2_q ? lvl8 : 8'h00;
`ifdef TILE_BORDER_EN
        if (bdr_s2_q) begin
          r_d = 8'hFF;
          g_d = 8'hFF;
          b_d = 8'hFF;
        end
`endif
      end else begin
        r_d = BG_R;
        g_d = BG_G;
        b_d = BG_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign oR = r_q;
  assign oG = g_q;
  assign oB = b_q;

endmodule

// File: tb/tb_tile_grid_compositor.sv
// Directed testbench for tile_grid_compositor with default parameters
// (6x6 grid, NT=36, LEVEL_W=4).
module tb_tile_grid_compositor;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x;
  logic [8:0] y;
  logic       valid;
  logic       wr_ready;
  logic [5:0] idx;
  logic [3:0] lvl;
  logic       wr_err;
  logic       swapped;
  logic [7:0] r, g, b;

  int checks   = 0;
  int failures = 0;
  int p;

  tile_grid_compositor dut (
    .clk      (clk),
    .reset    (reset),
    .iVGA_X   (x),
    .iVGA_Y   (y),
    .iWrValid (valid),
    .oWrReady (wr_ready),
    .iWrIdx   (idx),
    .iWrLevel (lvl),
    .oWrErr   (wr_err),
    .oSwapped (swapped),
    .oR       (r),
    .oG       (g),
    .oB       (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rgb(input string tag, input logic [7:0] er, input logic [7:0] eg,
                     input logic [7:0] eb);
    chk({tag, "_R"}, 32'(r), 32'(er));
    chk({tag, "_G"}, 32'(g), 32'(eg));
    chk({tag, "_B"}, 32'(b), 32'(eb));
    $display("pixel %s: rgb=%02h,%02h,%02h expected %02h,%02h,%02h", tag, r, g, b, er, eg, eb);
  endtask

  // Present a pixel and wait out the 3-cycle pipeline.
  task automatic pix(input int px, input int py);
    x = 10'(px);
    y = 9'(py);
    repeat (3) tick();
  endtask

  task automatic wr(input int i, input int l);
    idx   = 6'(i);
    lvl   = 4'(l);
    valid = 1'b1;
    chk("wr_ready", 32'(wr_ready), 32'd1);
    tick();
    valid = 1'b0;
    $display("write idx=%0d level=%0h", i, l);
  endtask

  // One frame start at (0,0), then park outside the grid; count oSwapped pulses.
  task automatic frame(output int pulses);
    x = 10'd0;
    y = 9'd0;
    pulses = 0;
    tick();
    if (swapped) pulses++;
    x = 10'd700;
    y = 9'd400;
    repeat (3) begin
      tick();
      if (swapped) pulses++;
    end
    $display("frame start: swap pulses=%0d", pulses);
  endtask

  initial begin
    reset = 1'b1;
    x = 10'd12;
    y = 9'd12;
    valid = 1'b0;
    idx = '0;
    lvl = '0;
    repeat (3) tick();
    rgb("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_ready", 32'(wr_ready), 32'd1);
    chk("reset_err", 32'(wr_err), 32'd0);
    chk("reset_swapped", 32'(swapped), 32'd0);
    reset = 1'b0;
    pix(12, 12);
    rgb("post_reset", 8'h00, 8'h00, 8'h00);

    // Write is shadowed until frame start.
    wr(0, 'hF);
    pix(12, 12);
    rgb("shadowed", 8'h00, 8'h00, 8'h00);
    frame(p);
    chk("swap1_pulses", 32'(p), 32'd1);
    pix(12, 12);
    rgb("tile0_F", 8'hFF, 8'h7F, 8'h00);

    // Odd column sets blue; gap is background.
    wr(6, 'h8);
    frame(p);
    chk("swap2_pulses", 32'(p), 32'd1);
    pix(116, 12);
    rgb("tile6_8", 8'h88, 8'h44, 8'h88);
    pix(110, 12);
    rgb("gap", 8'h00, 8'h00, 8'h00);
    pix(104, 12);
    rgb("tile0_right_edge", 8'hFF, 8'h7F, 8'h00);
    pix(105, 12);
    rgb("tile0_right_excl", 8'h00, 8'h00, 8'h00);

`ifdef TILE_BORDER_EN
    pix(10, 40);
    rgb("border", 8'hFF, 8'hFF, 8'hFF);
`else
    pix(10, 40);
    rgb("left_col", 8'hFF, 8'h7F, 8'h00);
`endif
    pix(11, 40);
    rgb("inner", 8'hFF, 8'h7F, 8'h00);

    // Out-of-range index: accepted, discarded, sticky error, no dirty.
    wr(36, 'h5);
    chk("err_set", 32'(wr_err), 32'd1);
    frame(p);
    chk("no_swap_after_bad_idx", 32'(p), 32'd0);
    chk("err_sticky", 32'(wr_err), 32'd1);
    pix(12, 12);
    rgb("tile0_kept", 8'hFF, 8'h7F, 8'h00);
    pix(116, 12);
    rgb("tile6_kept", 8'h88, 8'h44, 8'h88);

    // Write held across a swap cycle.
    wr(1, 'h3);
    x = 10'd0;
    y = 9'd0;
    idx = 6'd12;
    lvl = 4'hC;
    valid = 1'b1;
    #1;
    chk("ready_low_in_swap", 32'(wr_ready), 32'd0);
    tick();
    chk("swap3_pulse", 32'(swapped), 32'd1);
    chk("ready_after_swap", 32'(wr_ready), 32'd1);
    tick();
    valid = 1'b0;
    $display("held write idx=12 level=c completed after swap");
    chk("swap3_pulse_gone", 32'(swapped), 32'd0);
    pix(12, 90);
    rgb("tile1_3", 8'h33, 8'h19, 8'h00);
    pix(220, 12);
    rgb("tile12_shadowed", 8'h00, 8'h00, 8'h00);
    frame(p);
    chk("swap4_pulses", 32'(p), 32'd1);
    pix(220, 12);
    rgb("tile12_C", 8'hCC, 8'h66, 8'h00);
    pix(116, 12);
    rgb("tile6_after_copy", 8'h88, 8'h44, 8'h88);

    // Two frames with no writes: no swap.
    frame(p);
    chk("idle_frame1", 32'(p), 32'd0);
    frame(p);
    chk("idle_frame2", 32'(p), 32'd0);

    // Reset mid-frame flushes everything.
    pix(12, 12);
    rgb("before_reset", 8'hFF, 8'h7F, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rgb("in_reset", 8'h00, 8'h00, 8'h00);
    chk("err_cleared", 32'(wr_err), 32'd0);
    repeat (3) tick();
    rgb("after_reset", 8'h00, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
